// File: rtl/hit_sound_sequencer.sv
// hit_sound_sequencer
//   Converts per-bullet enemy-hit pulses into a short two-note buzzer chirp.
//   Each enemy class has its own timbre. Spider outranks mosquito, and
//   mosquito outranks fly. A new hit restarts the chirp only when its class
//   is equal to or higher than the class that is currently sounding.
//
//   Chirp shape: NOTE1 (NOTE_CYCLES) -> GAP (GAP_CYCLES, silent) -> NOTE2 (NOTE_CYCLES)
//     fly / mosquito : NOTE2 at half the half-period of NOTE1 (rising chirp)
//     spider         : NOTE2 at twice the half-period of NOTE1 (falling chirp)
//
// Ports
//   clk25         in   1             sole clock
//   reset         in   1             synchronous, active-high; overrides mute
//   mute          in   1             silences and aborts; hits are discarded while high
//   hit_fly       in   BULLET_COUNT  per-bullet fly hit pulses
//   hit_mosquito  in   BULLET_COUNT  per-bullet mosquito hit pulses
//   hit_spider    in   BULLET_COUNT  per-bullet spider hit pulses
//   buzz          out  1             registered square-wave buzzer drive
//   busy          out  1             registered; high while in NOTE1/GAP/NOTE2
//   cur_class     out  2             registered; 00 none, 01 fly, 10 mosquito, 11 spider
module hit_sound_sequencer #(
    parameter int unsigned BULLET_COUNT = 8,
    parameter int unsigned NOTE_CYCLES  = 1250000,
    parameter int unsigned GAP_CYCLES   = 250000,
    parameter int unsigned FLY_HALF     = 12500,
    parameter int unsigned MOSQ_HALF    = 8333,
    parameter int unsigned SPIDER_HALF  = 25000
) (
    input  logic                    clk25,
    input  logic                    reset,
    input  logic                    mute,
    input  logic [BULLET_COUNT-1:0] hit_fly,
    input  logic [BULLET_COUNT-1:0] hit_mosquito,
    input  logic [BULLET_COUNT-1:0] hit_spider,
    output logic                    buzz,
    output logic                    busy,
    output logic [1:0]              cur_class
);

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A half-period of zero would never wrap, so toggle every cycle instead.
    function automatic int unsigned clamp1(input int unsigned v);
        return (v < 1) ? 1 : v;
    endfunction

    localparam int unsigned CNT_MAX = max3(NOTE_CYCLES, GAP_CYCLES, 2 * SPIDER_HALF);
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    // Terminal half-period counts (H-1) for each class and note.
    localparam logic [CW-1:0] FLY_H1_LAST    = CW'(clamp1(FLY_HALF) - 1);
    localparam logic [CW-1:0] MOSQ_H1_LAST   = CW'(clamp1(MOSQ_HALF) - 1);
    localparam logic [CW-1:0] SPIDER_H1_LAST = CW'(clamp1(SPIDER_HALF) - 1);
    localparam logic [CW-1:0] FLY_H2_LAST    = CW'(clamp1(FLY_HALF / 2) - 1);
    localparam logic [CW-1:0] MOSQ_H2_LAST   = CW'(clamp1(MOSQ_HALF / 2) - 1);
    localparam logic [CW-1:0] SPIDER_H2_LAST = CW'(clamp1(SPIDER_HALF * 2) - 1);

    localparam logic [1:0] CLS_NONE   = 2'b00;
    localparam logic [1:0] CLS_FLY    = 2'b01;
    localparam logic [1:0] CLS_MOSQ   = 2'b10;
    localparam logic [1:0] CLS_SPIDER = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NOTE1 = 2'd1,
        GAP   = 2'd2,
        NOTE2 = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] dur_q;
    logic [CW-1:0] half_q;
    logic          buzz_q;
    logic          busy_q;
    logic [1:0]    class_q;

    logic [1:0]    req_class_d;
    logic          accept_d;
    logic [CW-1:0] half_last_d;
    logic          dur_last_d;

    always_comb begin
        req_class_d = CLS_NONE;
        if (|hit_spider) begin
            req_class_d = CLS_SPIDER;
        end else if (|hit_mosquito) begin
            req_class_d = CLS_MOSQ;
        end else if (|hit_fly) begin
            req_class_d = CLS_FLY;
        end

        accept_d = (req_class_d != CLS_NONE) &&
                   ((state_q == IDLE) || (req_class_d >= class_q));

        half_last_d = '0;
        case (class_q)
            CLS_FLY:    half_last_d = (state_q == NOTE2) ? FLY_H2_LAST    : FLY_H1_LAST;
            CLS_MOSQ:   half_last_d = (state_q == NOTE2) ? MOSQ_H2_LAST   : MOSQ_H1_LAST;
            CLS_SPIDER: half_last_d = (state_q == NOTE2) ? SPIDER_H2_LAST : SPIDER_H1_LAST;
            default:    half_last_d = '0;
        endcase

        dur_last_d = 1'b0;
        case (state_q)
            NOTE1, NOTE2: dur_last_d = (dur_q == NOTE_LAST);
            GAP:          dur_last_d = (dur_q == GAP_LAST);
            default:      dur_last_d = 1'b0;
        endcase
    end

    // Priority: reset, then mute (which also drops any hits), then an accepted
    // hit (which wins even over the final NOTE2 cycle), then normal sequencing.
    always_ff @(posedge clk25) begin
        if (reset || mute) begin
            state_q <= IDLE;
            dur_q   <= '0;
            half_q  <= '0;
            buzz_q  <= 1'b0;
            busy_q  <= 1'b0;
            class_q <= CLS_NONE;
        end else if (accept_d) begin
            state_q <= NOTE1;
            dur_q   <= '0;
            half_q  <= '0;
            buzz_q  <= 1'b0;
            busy_q  <= 1'b1;
            class_q <= req_class_d;
        end else begin
            case (state_q)
                IDLE: begin
                    dur_q  <= '0;
                    half_q <= '0;
                    buzz_q <= 1'b0;
                end
                NOTE1, NOTE2: begin
                    if (dur_last_d) begin
                        dur_q  <= '0;
                        half_q <= '0;
                        buzz_q <= 1'b0;
                        if (state_q == NOTE1) begin
                            state_q <= GAP;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            class_q <= CLS_NONE;
                        end
                    end else begin
                        dur_q <= dur_q + CW'(1);
                        if (half_q == half_last_d) begin
                            half_q <= '0;
                            buzz_q <= ~buzz_q;
                        end else begin
                            half_q <= half_q + CW'(1);
                        end
                    end
                end
                GAP: begin
                    buzz_q <= 1'b0;
                    half_q <= '0;
                    if (dur_last_d) begin
                        dur_q   <= '0;
                        state_q <= NOTE2;
                    end else begin
                        dur_q <= dur_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    dur_q   <= '0;
                    half_q  <= '0;
                    buzz_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    class_q <= CLS_NONE;
                end
            endcase
        end
    end

    assign buzz      = buzz_q;
    assign busy      = busy_q;
    assign cur_class = class_q;

endmodule

// File: tb/tb_hit_sound_sequencer.sv
// Scoreboarded bench for hit_sound_sequencer. The reference model tracks a
// chirp as "class + cycles since start" and derives outputs arithmetically.
module tb_hit_sound_sequencer;

    localparam int BC     = 8;
    localparam int NOTE   = 20;
    localparam int GAPC   = 4;
    localparam int FLYH   = 4;
    localparam int MOSQH  = 3;
    localparam int SPIH   = 5;
    localparam int CHIRP  = 2 * NOTE + GAPC;

    logic          clk25 = 1'b0;
    logic          reset = 1'b0;
    logic          mute  = 1'b0;
    logic [BC-1:0] hit_fly      = '0;
    logic [BC-1:0] hit_mosquito = '0;
    logic [BC-1:0] hit_spider   = '0;
    logic          buzz;
    logic          busy;
    logic [1:0]    cur_class;

    hit_sound_sequencer #(
        .BULLET_COUNT(BC),
        .NOTE_CYCLES (NOTE),
        .GAP_CYCLES  (GAPC),
        .FLY_HALF    (FLYH),
        .MOSQ_HALF   (MOSQH),
        .SPIDER_HALF (SPIH)
    ) dut (
        .clk25       (clk25),
        .reset       (reset),
        .mute        (mute),
        .hit_fly     (hit_fly),
        .hit_mosquito(hit_mosquito),
        .hit_spider  (hit_spider),
        .buzz        (buzz),
        .busy        (busy),
        .cur_class   (cur_class)
    );

    always #5 clk25 = ~clk25;

    typedef struct {
        int   step;
        logic buzz;
        logic busy;
        logic [1:0] cls;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // Reference model state: a chirp is active for CHIRP cycles after acceptance.
    bit m_act = 0;
    int m_cls = 0;
    int m_t   = 0;

    function automatic int half1(input int c);
        int h;
        h = (c == 1) ? FLYH : (c == 2) ? MOSQH : SPIH;
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int half2(input int c);
        int h;
        h = (c == 1) ? FLYH / 2 : (c == 2) ? MOSQH / 2 : SPIH * 2;
        return (h < 1) ? 1 : h;
    endfunction

    function automatic logic model_buzz();
        if (!m_act) return 1'b0;
        if (m_t < NOTE) return 1'(((m_t / half1(m_cls)) % 2));
        if (m_t < NOTE + GAPC) return 1'b0;
        return 1'(((m_t - NOTE - GAPC) / half2(m_cls)) % 2);
    endfunction

    // Drive one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input bit r, input bit mu, input logic [BC-1:0] f,
                        input logic [BC-1:0] m, input logic [BC-1:0] s);
        int   req;
        exp_t e;
        @(negedge clk25);
        reset        = r;
        mute         = mu;
        hit_fly      = f;
        hit_mosquito = m;
        hit_spider   = s;
        if (r || mu) begin
            m_act = 0; m_cls = 0; m_t = 0;
        end else begin
            req = (s != 0) ? 3 : (m != 0) ? 2 : (f != 0) ? 1 : 0;
            if (req != 0 && (!m_act || req >= m_cls)) begin
                m_act = 1; m_cls = req; m_t = 0;
            end else if (m_act) begin
                m_t++;
                if (m_t >= CHIRP) begin
                    m_act = 0; m_cls = 0; m_t = 0;
                end
            end
        end
        step_no++;
        e.step = step_no;
        e.buzz = model_buzz();
        e.busy = m_act;
        e.cls  = m_act ? 2'(m_cls) : 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0);
    endtask

    // Monitor: the DUT presents a new output set every edge; compare it with
    // the oldest pending prediction.
    always @(posedge clk25) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (buzz !== e.buzz) begin
                errors++;
                $display("FAIL buzz step=%0d got=%b exp=%b", e.step, buzz, e.buzz);
            end
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL busy step=%0d got=%b exp=%b", e.step, busy, e.busy);
            end
            checks++;
            if (cur_class !== e.cls) begin
                errors++;
                $display("FAIL cur_class step=%0d got=%b exp=%b", e.step, cur_class, e.cls);
            end
        end
    end

    initial begin
        // Reset, then quiet period.
        for (int i = 0; i < 3; i++) step(1, 0, '0, '0, '0);
        idle(100);

        // Lone fly chirp.
        step(0, 0, 8'h01, '0, '0);
        idle(50);

        // Fly and spider together: spider wins.
        step(0, 0, 8'h01, '0, 8'h80);
        idle(50);

        // Spider running, fly at NOTE1 cycle 5 is ignored.
        step(0, 0, '0, '0, 8'h10);
        idle(5);
        step(0, 0, 8'h01, '0, '0);
        idle(45);

        // Fly in GAP, mosquito restarts.
        step(0, 0, 8'h01, '0, '0);
        idle(21);
        step(0, 0, '0, 8'h06, '0);
        idle(50);

        // Mute mid-NOTE2, spider while muted is discarded.
        step(0, 0, '0, '0, 8'h01);
        idle(30);
        step(0, 1, '0, '0, '0);
        step(0, 1, '0, '0, 8'hFF);
        step(0, 1, 8'h03, 8'h01, 8'h40);
        idle(10);

        // Equal-class hit on the final NOTE2 cycle retriggers.
        step(0, 0, 8'h01, '0, '0);
        idle(CHIRP - 1);
        step(0, 0, 8'h20, '0, '0);
        idle(50);

        // Reset overrides a chirp in progress.
        step(0, 0, '0, 8'h01, '0);
        idle(10);
        step(1, 1, '0, '0, 8'h01);
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [BC-1:0] f, m, s;
            bit r, mu;
            f  = ($urandom_range(0, 29) == 0) ? BC'($urandom_range(1, 255)) : '0;
            m  = ($urandom_range(0, 39) == 0) ? BC'($urandom_range(1, 255)) : '0;
            s  = ($urandom_range(0, 59) == 0) ? BC'($urandom_range(1, 255)) : '0;
            mu = ($urandom_range(0, 149) == 0);
            r  = ($urandom_range(0, 499) == 0);
            step(r, mu, f, m, s);
        end
        idle(2);

        @(posedge clk25);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
